row_chunk_feeder: RTL and testbench

- Producer and collector for the eight-wide row reduction organizer in the matrix-vector datapath.
- Reads matrix-row chunks (NI x 32-bit words per chunk) from a chunk memory and streams them back-to-back, one chunk per cycle, into the organizer's row input.
- Marks the first chunk of every row with a one-cycle pulse, which drives the organizer's row-start control input.
- Counts the organizer's per-row result-valid pulses and writes each 32-bit row result to a result buffer; signals completion when every row result is stored.

---
 rtl/row_chunk_feeder.sv | 185 ++++++++++++++++++
 tb/tb_row_chunk_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_chunk_feeder.sv
// row_chunk_feeder
//
// Producer and collector for the eight-wide row reduction organizer.
// It reads matrix-row chunks (NI x 32-bit words) from chunk memory and
// streams them to the organizer with no gaps, one chunk per cycle. The
// first chunk of each row is marked with a one-cycle pulse. The block then
// collects one result per row from the organizer into a result buffer and
// pulses done once every row result has been stored.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   go                 start pulse, sampled only while idle
//   base_addr          chunk address of row 0 chunk 0 (latched on go)
//   num_rows           rows to process (latched on go)
//   chunks_per_row     chunks per row, 0 treated as 1 (latched on go)
//   mem_rd_en/mem_addr chunk memory read strobe and address
//   mem_rdata          read data, valid one cycle after mem_rd_en
//   adder_row_input    registered chunk to the organizer (zero when idle)
//   row_first          pulse aligned with the first chunk of each row
//   stream_active      organizer start level
//   result_in/_valid   organizer row result and its valid pulse
//   res_wr_en/res_addr/res_data  result buffer write port
//   busy, done         run status, one-cycle completion pulse
//   err_overrun        sticky: result with no row outstanding
module row_chunk_feeder #(
  parameter int NI     = 8,
  parameter int ADDR_W = 10,
  parameter int RES_W  = 8,
  parameter int CH_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [RES_W-1:0]  num_rows,
  input  logic [CH_W-1:0]   chunks_per_row,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NI*32-1:0]  mem_rdata,
  output logic [NI*32-1:0]  adder_row_input,
  output logic              row_first,
  output logic              stream_active,
  input  logic [31:0]       result_in,
  input  logic              result_valid,
  output logic              res_wr_en,
  output logic [RES_W-1:0]  res_addr,
  output logic [31:0]       res_data,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [RES_W-1:0]  nrows_q;
  logic [CH_W-1:0]   cpr_q;
  logic [CH_W-1:0]   chunk_cnt;
  logic [RES_W-1:0]  row_cnt;
  logic [RES_W-1:0]  res_cnt;
  logic              vld_p1;
  logic              first_p1;

  logic [CH_W-1:0]   cpr_eff;
  logic              last_chunk;
  logic              last_read;
  logic              rows_done;

  assign cpr_eff    = (chunks_per_row == '0) ? CH_W'(1) : chunks_per_row;
  assign last_chunk = (chunk_cnt == cpr_q - CH_W'(1));
  assign last_read  = last_chunk && (row_cnt == nrows_q - RES_W'(1));
  assign rows_done  = (res_cnt == nrows_q);

  // Control FSM, address generation and result collection.
  // mem_rd_en/mem_addr form the issue stage (p0) of the read pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      nrows_q       <= '0;
      cpr_q         <= '0;
      chunk_cnt     <= '0;
      row_cnt       <= '0;
      res_cnt       <= '0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      stream_active <= 1'b0;
      res_wr_en     <= 1'b0;
      res_addr      <= '0;
      res_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      done      <= 1'b0;
      res_wr_en <= 1'b0;

      // The organizer start level rises with the first chunk it sees.
      if (vld_p1) stream_active <= 1'b1;

      // Results are accepted in every active state, FETCH included, so an
      // early result is never lost.
      if (state != IDLE && result_valid) begin
        if (rows_done) begin
          err_overrun <= 1'b1;
        end else begin
          res_wr_en <= 1'b1;
          res_addr  <= res_cnt;
          res_data  <= result_in;
          res_cnt   <= res_cnt + RES_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (go) begin
            nrows_q     <= num_rows;
            cpr_q       <= cpr_eff;
            chunk_cnt   <= '0;
            row_cnt     <= '0;
            res_cnt     <= '0;
            mem_addr    <= base_addr;
            err_overrun <= 1'b0;
            if (num_rows == '0) begin
              state <= DONE;
            end else begin
              state     <= FETCH;
              mem_rd_en <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (last_read) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            if (last_chunk) begin
              chunk_cnt <= '0;
              row_cnt   <= row_cnt + RES_W'(1);
            end else begin
              chunk_cnt <= chunk_cnt + CH_W'(1);
            end
          end
        end
        DRAIN: begin
          // Clearing stream_active here takes priority over the set above.
          if (rows_done) begin
            state         <= DONE;
            busy          <= 1'b0;
            stream_active <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1          <= 1'b0;
      first_p1        <= 1'b0;
      adder_row_input <= '0;
      row_first       <= 1'b0;
    end else begin
      // p0 -> p1: read in flight, memory data arrives during p1
      vld_p1   <= mem_rd_en;
      first_p1 <= mem_rd_en && (chunk_cnt == '0);
      // p1 -> p2: register the chunk, zero when nothing is in flight
      adder_row_input <= vld_p1 ? mem_rdata : '0;
      row_first       <= vld_p1 && first_p1;
    end
  end

endmodule

// File: tb/tb_row_chunk_feeder.sv
module tb_row_chunk_feeder;
  localparam int NI     = 8;
  localparam int ADDR_W = 10;
  localparam int RES_W  = 8;
  localparam int CH_W   = 6;
  localparam int W      = NI * 32;
  localparam int BIG    = 32'h3fff_ffff;
  localparam int AMOD   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              go = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [RES_W-1:0]  num_rows = '0;
  logic [CH_W-1:0]   chunks_per_row = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_rdata = '0;
  logic [W-1:0]      adder_row_input;
  logic              row_first;
  logic              stream_active;
  logic [31:0]       result_in = '0;
  logic              result_valid = 1'b0;
  logic              res_wr_en;
  logic [RES_W-1:0]  res_addr;
  logic [31:0]       res_data;
  logic              busy;
  logic              done;
  logic              err_overrun;

  row_chunk_feeder #(.NI(NI), .ADDR_W(ADDR_W), .RES_W(RES_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .base_addr(base_addr), .num_rows(num_rows),
    .chunks_per_row(chunks_per_row), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .adder_row_input(adder_row_input), .row_first(row_first),
    .stream_active(stream_active), .result_in(result_in), .result_valid(result_valid),
    .res_wr_en(res_wr_en), .res_addr(res_addr), .res_data(res_data), .busy(busy),
    .done(done), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chunk memory: word k has lane l = k + l*lane_scale.
  logic [31:0] lane_scale = 32'd0;
  function automatic logic [W-1:0] word(input int k);
    logic [W-1:0] v;
    for (int l = 0; l < NI; l++) v[l*32 +: 32] = 32'(k % AMOD) + 32'(l) * lane_scale;
    return v;
  endfunction

  always @(posedge clk) mem_rdata <= mem_rd_en ? word(int'(mem_addr)) : {NI{32'hdead_beef}};

  // Behavioural model of the current run
  int m_g = 0, m_base = 0, m_R = 0, m_C = 1, m_N = 0;
  int m_abort = BIG, m_dstate = -10, m_done = -10;
  int m_err_from = BIG, m_err_prev = BIG, ovr_cyc = BIG;
  int res_cyc [256];
  logic [31:0] res_val [256];
  int drv_ptr = 0, drv_cnt = 0;

  // Observation logs
  int rd_q[$];
  int first_q[$];
  int wr_a[$];
  logic [31:0] wr_d[$];
  int n_done = 0;
  int done_seen = -1;

  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int exp_wrap [4] = '{1022, 1023, 0, 1};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int c, j, kw;
    logic live, e_rd, e_v, e_first, e_wr, e_busy, e_str, e_done, e_err;
    logic [W-1:0] e_data;
    if (chk_en) begin
      c    = cyc;
      live = (c < m_abort);
      e_rd = live && c >= m_g && c < m_g + m_N;
      j    = c - m_g - 2;
      e_v  = live && j >= 0 && j < m_N;
      e_data  = e_v ? word(m_base + j) : '0;
      e_first = e_v && (j % m_C == 0);
      e_wr = 1'b0;
      kw   = 0;
      for (int k = 0; k < m_R; k++)
        if (res_cyc[k] + 1 == c) begin
          e_wr = live;
          kw   = k;
        end
      e_busy = live && m_R > 0 && c >= m_g && c < m_dstate;
      e_str  = live && m_R > 0 && c >= m_g + 2 && c < m_dstate;
      e_done = live && c == m_done;
      e_err  = (c < m_g) ? (c >= m_err_prev) : (c >= m_err_from);

      check("mem_rd_en", W'(mem_rd_en), W'(e_rd));
      if (e_rd) check("mem_addr", W'(mem_addr), W'((m_base + c - m_g) % AMOD));
      check("adder_row_input", adder_row_input, e_data);
      check("row_first", W'(row_first), W'(e_first));
      check("res_wr_en", W'(res_wr_en), W'(e_wr));
      if (e_wr) begin
        check("res_addr", W'(res_addr), W'(kw));
        check("res_data", W'(res_data), W'(res_val[kw]));
      end
      check("busy", W'(busy), W'(e_busy));
      check("stream_active", W'(stream_active), W'(e_str));
      check("done", W'(done), W'(e_done));
      check("err_overrun", W'(err_overrun), W'(e_err));

      if (mem_rd_en === 1'b1) rd_q.push_back(int'(mem_addr));
      if (row_first === 1'b1) first_q.push_back(c);
      if (res_wr_en === 1'b1) begin
        wr_a.push_back(int'(res_addr));
        wr_d.push_back(res_data);
      end
      if (done === 1'b1) begin
        n_done++;
        done_seen = c;
      end
    end
  end

  // One cycle: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    go = 1'b0;
    result_valid = 1'b0;
    if (drv_ptr < drv_cnt && res_cyc[drv_ptr] == cyc) begin
      result_valid = 1'b1;
      result_in    = res_val[drv_ptr];
      drv_ptr++;
    end else if (cyc == ovr_cyc) begin
      result_valid = 1'b1;
      result_in    = 32'hbad0_bad0;
    end
  endtask

  // Pulse go and build the expected run: reads, chunks, result schedule, done.
  task automatic start_run(input int base, input int rows, input int cpr,
                           input int lat_lo, input int lat_hi, input bit early, input bit ovr);
    int p, wl;
    step();
    go = 1'b1;
    base_addr = ADDR_W'(base);
    num_rows = RES_W'(rows);
    chunks_per_row = CH_W'(cpr);
    rd_q.delete(); first_q.delete(); wr_a.delete(); wr_d.delete();
    n_done = 0;
    done_seen = -1;
    m_err_prev = m_err_from;
    m_err_from = BIG;
    m_g = cyc + 1;
    m_base = base % AMOD;
    m_R = rows;
    m_C = (cpr == 0) ? 1 : cpr;
    m_N = m_R * m_C;
    m_abort = BIG;
    ovr_cyc = BIG;
    for (int r = 0; r < m_R; r++) begin
      if (early) p = (r == m_R - 1) ? m_g + m_N - 1 : m_g + 3 + r;
      else p = m_g + 1 + (r + 1) * m_C + int'($urandom_range(lat_hi, lat_lo));
      if (r > 0 && p <= res_cyc[r-1]) p = res_cyc[r-1] + 1;
      res_cyc[r] = p;
      res_val[r] = 32'd0;
      for (int q = 0; q < m_C; q++) res_val[r] = res_val[r] + 32'((m_base + r * m_C + q) % AMOD);
    end
    if (m_R == 0) begin
      m_dstate = m_g;
    end else begin
      wl = res_cyc[m_R-1] + 1;
      m_dstate = ((wl > m_g + m_N) ? wl : m_g + m_N) + 1;
      if (ovr) begin
        ovr_cyc = wl;
        m_err_from = wl + 1;
      end
    end
    m_done = m_dstate + 1;
    drv_ptr = 0;
    drv_cnt = m_R;
  endtask

  task automatic finish_run();
    while (cyc < m_done + 2) step();
  endtask

  initial begin
    int rows;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic run: word k = all lanes k, row sums 3 and 12
    lane_scale = 32'd0;
    start_run(0, 2, 3, 3, 3, 1'b0, 1'b0);
    finish_run();
    check_int("basic_reads", rd_q.size(), 6);
    for (int i = 0; i < 6; i++) check_int("basic_addr", rd_q[i], i);
    check_int("basic_first_cnt", first_q.size(), 2);
    check_int("basic_first0_ofs", first_q[0] - m_g, 2);
    check_int("basic_first1_ofs", first_q[1] - m_g, 5);
    check_int("basic_writes", wr_a.size(), 2);
    check_int("basic_wr0_addr", wr_a[0], 0);
    check_int("basic_wr0_data", int'(wr_d[0]), 3);
    check_int("basic_wr1_addr", wr_a[1], 1);
    check_int("basic_wr1_data", int'(wr_d[1]), 12);
    check_int("basic_done_cnt", n_done, 1);

    // Address wrap
    lane_scale = 32'h0010_0000;
    start_run(1022, 1, 4, 2, 5, 1'b0, 1'b0);
    finish_run();
    check_int("wrap_reads", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) check_int("wrap_addr", rd_q[i], exp_wrap[i]);
    check_int("wrap_first_cnt", first_q.size(), 1);

    // num_rows = 0: done on the 2nd cycle after the go cycle, no reads
    start_run(7, 0, 5, 1, 1, 1'b0, 1'b0);
    finish_run();
    check_int("zero_rows_reads", rd_q.size(), 0);
    check_int("zero_rows_done_ofs", done_seen - (m_g - 1), 2);
    check_int("zero_rows_done_cnt", n_done, 1);

    // chunks_per_row = 0 behaves as 1
    start_run(300, 3, 0, 1, 6, 1'b0, 1'b0);
    finish_run();
    check_int("cpr0_reads", rd_q.size(), 3);
    check_int("cpr0_firsts", first_q.size(), 3);
    check_int("cpr0_writes", wr_a.size(), 3);

    // Early results: one during FETCH, the last on the final read cycle
    start_run(50, 2, 3, 0, 0, 1'b1, 1'b0);
    finish_run();
    check_int("early_writes", wr_a.size(), 2);
    check_int("early_done_ofs", done_seen - m_g, 8);

    // Overrun plus a go pulse while busy
    start_run(200, 3, 2, 2, 6, 1'b0, 1'b1);
    step();
    step();
    go = 1'b1;
    num_rows = RES_W'(5);
    base_addr = ADDR_W'(9);
    chunks_per_row = CH_W'(1);
    finish_run();
    check_int("ovr_err", int'(err_overrun), 1);
    check_int("ovr_writes", wr_a.size(), 3);
    check_int("ovr_reads", rd_q.size(), 6);
    check_int("ovr_done_cnt", n_done, 1);

    // The next go clears err_overrun
    start_run(400, 1, 2, 1, 3, 1'b0, 1'b0);
    step();
    check_int("err_cleared", int'(err_overrun), 0);
    finish_run();

    // Reset during the 4th read
    start_run(100, 2, 5, 4, 8, 1'b0, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    m_abort = cyc + 1;
    drv_cnt = 0;
    step();
    rst_n = 1'b1;
    check_int("abort_busy", int'(busy), 0);
    repeat (3) step();
    check_int("abort_reads", rd_q.size(), 4);
    check_int("abort_done_cnt", n_done, 0);

    // Restart from a newly latched base
    start_run(600, 1, 3, 1, 4, 1'b0, 1'b0);
    finish_run();
    check_int("restart_addr0", rd_q[0], 600);
    check_int("restart_done_cnt", n_done, 1);

    // Random runs
    for (int t = 0; t < 4; t++) begin
      lane_scale = $urandom;
      rows = int'($urandom_range(6, 1));
      start_run(int'($urandom_range(1023, 0)), rows, int'($urandom_range(5, 0)), 1, 11, 1'b0, 1'b0);
      finish_run();
      check_int("rand_writes", wr_a.size(), rows);
    end

    // Long run: 255 rows, random result latency
    start_run(17, 255, 1, 1, 11, 1'b0, 1'b0);
    finish_run();
    check_int("long_writes", wr_a.size(), 255);
    for (int i = 0; i < 255; i++) check_int("long_order", wr_a[i], i);
    check_int("long_done_cnt", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
